// File: rtl/mips_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Operation codes, FSM states and the iteration count.
package mips_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU
   } muldiv_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIXUP
   } muldiv_state_t;

   localparam int MD_ITERS = 32;

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the HI/LO datapath.
// Radix-2 shift-add for multiply, restoring step for divide.
module muldiv_step (
   input  logic        i_div,
   input  logic [63:0] i_acc,
   input  logic        i_bit,
   input  logic [31:0] i_opnd,
   output logic [63:0] o_acc
);

   logic [32:0] w_sum;
   logic [32:0] w_rem;
   logic [32:0] w_diff;

   // multiply adds into the upper half then shifts right;
   // divide shifts the next dividend bit into the remainder
   // and keeps the trial difference when it does not borrow
   always_comb begin
      w_sum  = {1'b0, i_acc[63:32]}
             + (i_bit ? {1'b0, i_opnd} : 33'd0);
      w_rem  = {i_acc[63:32], i_bit};
      w_diff = w_rem - {1'b0, i_opnd};
      if (i_div) begin
         if (w_diff[32])
            o_acc = {w_rem[31:0], i_acc[30:0], 1'b0};
         else
            o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
      end else begin
         o_acc = {w_sum, i_acc[31:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// HI/LO sequencer: MULT/MULTU/DIV/DIVU over 32 iterations,
// MTHI/MTLO writes and the PC stall while busy.
module mips_muldiv_ctrl
   import mips_muldiv_pkg::*;
#(
   parameter int ITERS = MD_ITERS
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        rd_req,
   input  logic        cancel,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall,
   output logic        done
);

   localparam logic [4:0] LP_LAST = 5'(ITERS - 1);

   muldiv_state_t r_state;
   muldiv_op_t    r_op;
   logic [4:0]    r_count;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_rs;
   logic          r_neg_q;
   logic          r_neg_r;
   logic          r_dz;
   logic [63:0]   r_acc;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic          r_done;

   muldiv_op_t    w_op;
   logic          w_sgn;
   logic          w_rs_neg;
   logic          w_rt_neg;
   logic          w_div;
   logic          w_bit;
   logic [31:0]   w_opnd;
   logic [63:0]   w_step;
   logic [63:0]   w_prod_n;
   logic [31:0]   w_fix_hi;
   logic [31:0]   w_fix_lo;

   // operand conditioning at issue and per-iteration selects
   always_comb begin
      w_op     = muldiv_op_t'(op);
      w_sgn    = (w_op == OP_MULT) || (w_op == OP_DIV);
      w_rs_neg = w_sgn & rs_data[31];
      w_rt_neg = w_sgn & rt_data[31];
      w_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
      w_bit    = w_div ? r_a[31] : r_b[0];
      w_opnd   = w_div ? r_b : r_a;
   end

   muldiv_step u_step (
      .i_div  (w_div),
      .i_acc  (r_acc),
      .i_bit  (w_bit),
      .i_opnd (w_opnd),
      .o_acc  (w_step)
   );

   // sign correction and divide-by-zero result
   always_comb begin
      w_prod_n = -r_acc;
      w_fix_hi = r_acc[63:32];
      w_fix_lo = r_acc[31:0];
      if (r_dz) begin
         w_fix_hi = r_rs;
         w_fix_lo = 32'hFFFF_FFFF;
      end else if (w_div) begin
         if (r_neg_r) w_fix_hi = -r_acc[63:32];
         if (r_neg_q) w_fix_lo = -r_acc[31:0];
      end else if (r_neg_q) begin
         w_fix_hi = w_prod_n[63:32];
         w_fix_lo = w_prod_n[31:0];
      end
   end

   // sequencer FSM, operand/accumulator and HI/LO registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= S_IDLE;
         r_op    <= OP_MULT;
         r_count <= 5'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_rs    <= 32'd0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_acc   <= 64'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (cancel) begin
            r_state <= S_IDLE;
            r_count <= 5'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state <= S_CALC;
                     r_op    <= w_op;
                     r_count <= 5'd0;
                     r_a     <= w_rs_neg ? -rs_data : rs_data;
                     r_b     <= w_rt_neg ? -rt_data : rt_data;
                     r_rs    <= rs_data;
                     r_neg_q <= w_rs_neg ^ w_rt_neg;
                     r_neg_r <= w_rs_neg;
                     r_dz    <= w_op[1] & (rt_data == 32'd0);
                     r_acc   <= 64'd0;
                  end else begin
                     if (mthi) r_hi <= rs_data;
                     if (mtlo) r_lo <= rs_data;
                  end
               end
               S_CALC: begin
                  r_acc   <= w_step;
                  r_count <= r_count + 5'd1;
                  if (w_div) r_a <= {r_a[30:0], 1'b0};
                  else       r_b <= {1'b0, r_b[31:1]};
                  if (r_count == LP_LAST) begin
                     r_state <= S_FIXUP;
                     r_count <= 5'd0;
                  end
               end
               S_FIXUP: begin
                  r_hi    <= w_fix_hi;
                  r_lo    <= w_fix_lo;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign done  = r_done;
   assign busy  = (r_state != S_IDLE);
   assign stall = busy & (start | rd_req | mthi | mtlo);

endmodule
